// File: rtl/mdu_e.sv
// E-stage multiply/divide unit owning HI/LO; fixed-latency MULT/DIV plus 1-cycle MT/MF.
// Optional MDU_CANCEL_EN adds a cancel input that aborts RUN and suppresses start/MTHI/MTLO.
module mdu_e #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  md_op,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          capture, commit, kill;
    logic [3:0]    op_q;
    logic [31:0]   a_q, b_q;

`ifdef MDU_CANCEL_EN
    assign kill = cancel;
`else
    assign kill = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !kill && md_op >= OP_MULT && md_op <= OP_DIVU) begin
                    capture   = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = (md_op == OP_MULT || md_op == OP_MULTU) ?
                                CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
                end
            end
            RUN: begin
                if (kill) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(1)) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are latched so forwarding changes after start cannot disturb the result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (capture) begin
            op_q <= md_op;
            a_q  <= a;
            b_q  <= b;
        end
    end

    logic        is_mul, is_signed;
    logic [63:0] a_ext, b_ext, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    assign is_mul    = (op_q == OP_MULT) || (op_q == OP_MULTU);
    assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);

    // Low 64 bits of the extended product are correct for both signed and unsigned.
    assign a_ext = {{32{is_signed & a_q[31]}}, a_q};
    assign b_ext = {{32{is_signed & b_q[31]}}, b_q};
    assign prod  = a_ext * b_ext;

    // Divide on magnitudes then restore signs; avoids the -2^31/-1 corner in signed '/'.
    assign a_neg = is_signed & a_q[31];
    assign b_neg = is_signed & b_q[31];
    assign a_mag = a_neg ? (32'd0 - a_q) : a_q;
    assign b_mag = b_neg ? (32'd0 - b_q) : b_q;
    assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            if (is_mul) begin
                hi <= prod[63:32];
                lo <= prod[31:0];
            end else if (b_q != 32'd0) begin
                hi <= rem;
                lo <= quot;
            end
        end else if (state == IDLE && !kill) begin
            if (md_op == OP_MTHI) hi <= a;
            if (md_op == OP_MTLO) lo <= a;
        end
    end

    assign busy   = (state == RUN);
    assign md_out = (md_op == OP_MFHI) ? hi :
                    (md_op == OP_MFLO) ? lo : 32'd0;
endmodule

// File: tb/tb_mdu_e.sv
// Directed self-checking bench for mdu_e (default MUL_CYCLES=5, DIV_CYCLES=10).
module tb_mdu_e;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  md_op;
    logic        start;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo, md_out;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif
    int checks = 0;
    int errors = 0;

    mdu_e dut (
        .clk(clk), .reset_n(reset_n), .md_op(md_op), .start(start), .a(a), .b(b),
`ifdef MDU_CANCEL_EN
        .cancel(cancel),
`endif
        .busy(busy), .hi(hi), .lo(lo), .md_out(md_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a long op and verify busy is high exactly n cycles, then low.
    task automatic run_op(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                          input int n, input string tag);
        md_op = op; start = 1'b1; a = va; b = vb;
        tick();
        start = 1'b0; md_op = 4'd0;
        for (int i = 0; i < n; i++) begin
            chk({tag, " busy"}, {31'd0, busy}, 32'd1);
            tick();
        end
        chk({tag, " busy end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; md_op = 4'd0; start = 1'b0; a = '0; b = '0;
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        tick(); reset_n = 1'b1; tick();

        run_op(4'd1, 32'hFFFFFFFD, 32'd5, 5, "mult");
        chk("mult hi", hi, 32'hFFFFFFFF);
        chk("mult lo", lo, 32'hFFFFFFF1);

        // MULTU with a changed after capture
        md_op = 4'd2; start = 1'b1; a = 32'hFFFFFFFF; b = 32'd2;
        tick();
        start = 1'b0; md_op = 4'd0; a = 32'd0;
        for (int i = 0; i < 5; i++) begin
            chk("multu busy", {31'd0, busy}, 32'd1);
            tick();
        end
        chk("multu busy end", {31'd0, busy}, 32'd0);
        chk("multu hi", hi, 32'h00000001);
        chk("multu lo", lo, 32'hFFFFFFFE);

        run_op(4'd3, 32'hFFFFFFF9, 32'd2, 10, "div");
        chk("div hi", hi, 32'hFFFFFFFF);
        chk("div lo", lo, 32'hFFFFFFFD);

        run_op(4'd3, 32'd7, 32'hFFFFFFFE, 10, "div neg divisor");
        chk("div2 hi", hi, 32'd1);
        chk("div2 lo", lo, 32'hFFFFFFFD);

        run_op(4'd4, 32'hFFFFFFFF, 32'h10, 10, "divu");
        chk("divu hi", hi, 32'h0000000F);
        chk("divu lo", lo, 32'h0FFFFFFF);

        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 10, "div ovf");
        chk("div ovf hi", hi, 32'd0);
        chk("div ovf lo", lo, 32'h80000000);

        run_op(4'd1, 32'h80000000, 32'h80000000, 5, "mult min");
        chk("mult min hi", hi, 32'h40000000);
        chk("mult min lo", lo, 32'd0);

        // Divide by zero leaves preloaded HI/LO untouched
        md_op = 4'd5; a = 32'h11; tick();
        chk("mthi busy", {31'd0, busy}, 32'd0);
        chk("mthi hi", hi, 32'h11);
        md_op = 4'd6; a = 32'h22; tick();
        chk("mtlo lo", lo, 32'h22);
        run_op(4'd4, 32'd7, 32'd0, 10, "divu by zero");
        chk("dz hi", hi, 32'h11);
        chk("dz lo", lo, 32'h22);

        // MTHI then MFHI/MFLO, plus non-read ops
        md_op = 4'd5; a = 32'h12345678; tick();
        md_op = 4'd7; #1;
        chk("mfhi", md_out, 32'h12345678);
        md_op = 4'd8; #1;
        chk("mflo", md_out, 32'h22);
        md_op = 4'd0; #1;
        chk("md_out none", md_out, 32'd0);
        md_op = 4'd12; #1;
        chk("md_out op12", md_out, 32'd0);
        chk("mt busy", {31'd0, busy}, 32'd0);

        // start with a non-long op is ignored
        md_op = 4'd9; start = 1'b1; a = 32'd3; b = 32'd3; tick();
        start = 1'b0; md_op = 4'd0;
        chk("start op9 busy", {31'd0, busy}, 32'd0);

        // MTHI and a second start during RUN are ignored
        md_op = 4'd1; start = 1'b1; a = 32'd3; b = 32'd4; tick();   // t+1
        start = 1'b0; md_op = 4'd5; a = 32'hDEAD; tick();            // t+2
        chk("mthi in run", hi, 32'h12345678);
        md_op = 4'd3; start = 1'b1; a = 32'd100; b = 32'd7; tick();  // t+3
        start = 1'b0; md_op = 4'd0;
        tick(); tick();                                              // t+5
        chk("run t+5 busy", {31'd0, busy}, 32'd1);
        tick();                                                      // t+6
        chk("run t+6 busy", {31'd0, busy}, 32'd0);
        chk("ignored start hi", hi, 32'd0);
        chk("ignored start lo", lo, 32'd12);

        // Reset mid-DIV
        md_op = 4'd5; a = 32'h55; tick();
        run_op(4'd0, 32'd0, 32'd0, 0, "nop");
        md_op = 4'd3; start = 1'b1; a = 32'd50; b = 32'd3; tick();   // t+1
        start = 1'b0; md_op = 4'd0; tick(); tick();                  // t+3
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0; #1;
        chk("mid reset busy", {31'd0, busy}, 32'd0);
        chk("mid reset hi", hi, 32'd0);
        chk("mid reset lo", lo, 32'd0);
        tick(); reset_n = 1'b1; tick();
        run_op(4'd1, 32'd3, 32'd4, 5, "post reset mult");
        chk("post reset hi", hi, 32'd0);
        chk("post reset lo", lo, 32'd12);
        tick();
        chk("no late commit", lo, 32'd12);

`ifdef MDU_CANCEL_EN
        md_op = 4'd5; a = 32'hA; tick();
        md_op = 4'd6; a = 32'hB; tick();
        md_op = 4'd1; start = 1'b1; a = 32'd6; b = 32'd7; tick();    // t+1
        start = 1'b0; md_op = 4'd0; tick();                          // t+2
        cancel = 1'b1; tick();                                       // t+3
        cancel = 1'b0;
        chk("cancel busy", {31'd0, busy}, 32'd0);
        chk("cancel hi", hi, 32'hA);
        chk("cancel lo", lo, 32'hB);
        md_op = 4'd1; start = 1'b1; cancel = 1'b1; tick();
        start = 1'b0; cancel = 1'b0; md_op = 4'd0;
        chk("cancel start busy", {31'd0, busy}, 32'd0);
        md_op = 4'd5; a = 32'hFF; cancel = 1'b1; tick();
        cancel = 1'b0; md_op = 4'd0;
        chk("cancel mthi", hi, 32'hA);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mdu_e.md
# mdu_e

Multi-cycle multiply/divide unit in the E stage of the five-stage pipeline, owning the HI/LO registers. Executes MULT/MULTU/DIV/DIVU with fixed latency and MTHI/MTLO/MFHI/MFLO in one cycle. Exports `start` and `busy` to the hazard stall unit, which holds any D-stage HI/LO instruction while either is high.

## Interface
Parameters:
- MUL_CYCLES, 5, cycles `busy` stays high for MULT/MULTU (≥1)
- DIV_CYCLES, 10, cycles `busy` stays high for DIV/DIVU (≥1)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- md_op  input  4  E-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9–15 treated as NONE
- start  input  1  asserted by E stage for one cycle when md_op is 1–4 and E holds a valid instruction
- a  input  32  forwarded rs value
- b  input  32  forwarded rt value
- busy  output  1  long operation in flight
- hi  output  32  current HI register
- lo  output  32  current LO register
- md_out  output  32  `hi` when md_op=7, `lo` when md_op=8, else 0 (combinational)

## Operation
- States: IDLE, RUN. Reset → IDLE, `busy`=0, `hi`=0, `lo`=0, counter=0.
- IDLE, `start`=1 with md_op 1–4: capture op, a, b; load counter with MUL_CYCLES or DIV_CYCLES; → RUN.
- RUN: `busy`=1; counter decrements each cycle; when counter reaches 1, commit result to HI/LO at that edge and → IDLE.
- Results from operands captured at `start`; later changes on `a`/`b` have no effect.
- MULT: signed 32×32→64; HI=upper, LO=lower. MULTU: unsigned.
- DIV: signed; LO=quotient truncated toward zero, HI=remainder with sign of dividend. DIVU: unsigned.
- Divide by zero (b=0 at capture): full DIV_CYCLES busy; HI/LO left unchanged.
- MTHI/MTLO (md_op 5/6): write `a` to HI/LO at the edge of that cycle; no `busy`. Only legal in IDLE; ignored in RUN.
- `start` while RUN, or with md_op not 1–4: ignored (stall unit prevents the former).
- md_op 7/8 read registers as currently held; valid only when `busy`=0 and no commit pending.

## Timing
- `start` at cycle t → `busy`=1 for cycles t+1 .. t+N (N = MUL_CYCLES or DIV_CYCLES); `busy`=0 at t+N+1.
- HI/LO updated at rising edge closing cycle t+N; new values visible at t+N+1 together with `busy` falling.
- Back-to-back: new `start` accepted at t+N+1.
- MTHI/MTLO at cycle t → `hi`/`lo` updated from t+1.
- `md_out` zero-latency from `md_op` and registers.
- reset_n low at any time, including mid-RUN: immediate return to IDLE, `busy`=0, HI/LO=0, pending result discarded.

## Configuration
- Macro `MDU_CANCEL_EN`.
- Defined: extra input `cancel` (1 bit). When `cancel`=1 on an edge in RUN: → IDLE, `busy`=0 next cycle, HI/LO unchanged. `cancel` together with `start` in IDLE: start suppressed. `cancel` also suppresses a same-cycle MTHI/MTLO write.
- Undefined: no `cancel` port; every accepted operation runs to completion.

## Test plan
- MULT a=0xFFFFFFFD, b=5 → `busy` high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=0xFFFFFFFF, b=2, with `a` changed to 0 at t+1 → hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- DIV a=0xFFFFFFF9 (−7), b=2 → `busy` 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 with HI/LO preloaded 0x11/0x22 via MTHI/MTLO → unchanged after 10 cycles.
- MTHI a=0x12345678 then md_op=7 next cycle → md_out=0x12345678; md_op=8 → md_out=lo; `busy` never asserted.
- Reset_n pulsed low at t+3 of a DIV → `busy`=0, hi=lo=0 immediately; next MULT 3×4 completes normally with lo=12, hi=0.
- With `MDU_CANCEL_EN`: cancel at t+2 of MULT after hi/lo=0xA/0xB → `busy`=0 at t+3, hi/lo still 0xA/0xB; second `start` during RUN ignored.
